// File: rtl/nfm_pkg.sv
// rtl/nfm_pkg.sv - shared mode encodings, Q3.6 constant table and default widths
package nfm_pkg;

    localparam int FIX_POINT_WIDTH_DEF = 16;
    localparam int BF_DEF              = 8;
    localparam int COEF_W_DEF          = 10;
    localparam int COEF_FRAC_DEF       = 6;

    localparam logic [2:0] MUL_ONE    = 3'd0;
    localparam logic [2:0] MUL_HALF   = 3'd1;
    localparam logic [2:0] MUL_LOG2E  = 3'd2;
    localparam logic [2:0] MUL_GELU   = 3'd3;
    localparam logic [2:0] MUL_SILU_P = 3'd4;
    localparam logic [2:0] MUL_SILU_N = 3'd5;
    localparam logic [2:0] MUL_NEG    = 3'd6;
    localparam logic [2:0] MUL_PROG   = 3'd7;

    // Q3.6 constants, rescaled in the datapath when COEF_FRAC exceeds 6
    localparam int COEF_ONE     = 64;
    localparam int COEF_HALF    = 32;
    localparam int COEF_LOG2E   = 92;
    localparam int COEF_GELU    = 164;
    localparam int COEF_SILU_P  = 91;
    localparam int COEF_SILU_N  = 67;
    localparam int COEF_NEG_ONE = -64;

endpackage

// File: rtl/round_sat.sv
// rtl/round_sat.sv - combinational round-half-up shift followed by signed saturation
module round_sat #(
    parameter int IN_W  = 26,
    parameter int OUT_W = 16,
    parameter int SHIFT = 6
) (
    input  logic signed [IN_W-1:0]  i_data,
    output logic signed [OUT_W-1:0] o_data,
    output logic                    o_sat
);

    // One guard bit so adding the half-LSB can never wrap
    localparam int SW = IN_W + 1;
    localparam logic signed [SW-1:0] HALF = {{(SW-1){1'b0}}, 1'b1} << (SHIFT - 1);
    localparam logic signed [SW-1:0] MAXV = {{(SW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [SW-1:0] MINV = {{(SW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [SW-1:0] w_ext;
    logic signed [SW-1:0] w_sum;
    logic signed [SW-1:0] w_shr;

    assign w_ext = {i_data[IN_W-1], i_data};
    assign w_sum = w_ext + HALF;
    assign w_shr = w_sum >>> SHIFT;

    always_comb begin
        o_data = w_shr[OUT_W-1:0];
        o_sat  = 1'b0;
        if (w_shr > MAXV) begin
            o_data = {1'b0, {(OUT_W-1){1'b1}}};
            o_sat  = 1'b1;
        end else if (w_shr < MINV) begin
            o_data = {1'b1, {(OUT_W-1){1'b0}}};
            o_sat  = 1'b1;
        end
    end

endmodule

// File: rtl/const_mul_pipe.sv
// rtl/const_mul_pipe.sv - two-stage handshaked constant multiplier with rounding and saturation
module const_mul_pipe
    import nfm_pkg::*;
#(
    parameter int FIX_POINT_WIDTH = FIX_POINT_WIDTH_DEF,
    parameter int Bf              = BF_DEF,
    parameter int COEF_W          = COEF_W_DEF,
    parameter int COEF_FRAC       = COEF_FRAC_DEF
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic signed [FIX_POINT_WIDTH-1:0] in_data,
    input  logic [2:0]                        s_mult,
    input  logic                              cfg_we,
    input  logic signed [COEF_W-1:0]          cfg_coef,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic signed [FIX_POINT_WIDTH-1:0] out_data,
    output logic                              out_sat
);

    localparam int PW = FIX_POINT_WIDTH + COEF_W;

    if (Bf >= FIX_POINT_WIDTH || COEF_FRAC < 6) begin : g_param_check
        $error("const_mul_pipe: Bf must be below the data width and COEF_FRAC at least 6");
    end

    function automatic logic signed [COEF_W-1:0] scale_q36(input int q36);
        return COEF_W'(q36 * (1 << (COEF_FRAC - 6)));
    endfunction

    logic signed [COEF_W-1:0]          r_coef;
    logic                              r_v1;
    logic signed [FIX_POINT_WIDTH-1:0] r_a;
    logic signed [COEF_W-1:0]          r_c;
    logic                              r_v2;
    logic signed [FIX_POINT_WIDTH-1:0] r_out;
    logic                              r_sat;

    logic                              w_adv1;
    logic                              w_adv2;
    logic signed [COEF_W-1:0]          w_coef_sel;
    logic signed [PW-1:0]              w_prod;
    logic signed [FIX_POINT_WIDTH-1:0] w_rs_data;
    logic                              w_rs_sat;

    assign w_adv2   = !r_v2 || out_ready;
    assign w_adv1   = !r_v1 || w_adv2;
    assign in_ready = w_adv1;

    // Mode 7 reads the register value before any same-cycle write lands
    always_comb begin
        w_coef_sel = r_coef;
        case (s_mult)
            MUL_ONE:    w_coef_sel = scale_q36(COEF_ONE);
            MUL_HALF:   w_coef_sel = scale_q36(COEF_HALF);
            MUL_LOG2E:  w_coef_sel = scale_q36(COEF_LOG2E);
            MUL_GELU:   w_coef_sel = scale_q36(COEF_GELU);
            MUL_SILU_P: w_coef_sel = scale_q36(COEF_SILU_P);
            MUL_SILU_N: w_coef_sel = scale_q36(COEF_SILU_N);
            MUL_NEG:    w_coef_sel = scale_q36(COEF_NEG_ONE);
            MUL_PROG:   w_coef_sel = r_coef;
            default:    w_coef_sel = r_coef;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_coef <= scale_q36(COEF_ONE);
        end else if (cfg_we) begin
            r_coef <= cfg_coef;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_v1 <= 1'b0;
            r_a  <= '0;
            r_c  <= '0;
        end else if (w_adv1) begin
            r_v1 <= in_valid;
            if (in_valid) begin
                r_a <= in_data;
                r_c <= w_coef_sel;
            end
        end
    end

    assign w_prod = r_a * r_c;

    round_sat #(
        .IN_W  (PW),
        .OUT_W (FIX_POINT_WIDTH),
        .SHIFT (COEF_FRAC)
    ) u_round_sat (
        .i_data (w_prod),
        .o_data (w_rs_data),
        .o_sat  (w_rs_sat)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_v2  <= 1'b0;
            r_out <= '0;
            r_sat <= 1'b0;
        end else if (w_adv2) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_out <= w_rs_data;
                r_sat <= w_rs_sat;
            end
        end
    end

    assign out_valid = r_v2;
    assign out_data  = r_out;
    assign out_sat   = r_sat;

endmodule
